bcd_counter_top: RTL and testbench
==================================

BCD_COUNTER_TOP -- requirements
Module: bcd_counter_top

Interface
REQ-001 The block SHALL take parameter DIGITS, default 4, giving the number of BCD digits (range 1..8).
REQ-002 The block SHALL take parameter DEBOUNCE_CYCLES, default 250000, giving the number of stable cycles required before a button level is accepted.
REQ-003 The block SHALL take parameter REFRESH_CYCLES, default 50000, giving the number of cycles each display digit stays enabled.
REQ-004 The block SHALL take parameter LZ_BLANK, default 0; when 1, leading zeros are blanked.
REQ-005 clk  input  1  the single system clock; all state SHALL be clocked on its rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 Btn1  input  1  raw, asynchronous count-up button.
REQ-008 Btn2  input  1  raw, asynchronous count-down button.
REQ-009 Led1  output  1  registered copy of the debounced Btn1 level.
REQ-010 Count  output  4*DIGITS  packed BCD count; digit 0 is in bits [3:0].
REQ-011 Leds7Seg  output  7  active-low segments in gfedcba order (bit 6 = g).
REQ-012 Enable7Seg  output  DIGITS  active-low, one-hot digit enables.

Function
REQ-013 Each button SHALL pass through a 2-flop synchroniser, then a stability counter.
- The clean level updates only after DEBOUNCE_CYCLES consecutive identical synchronised samples that differ from the current clean level.
- Any mismatch resets the stability counter to 0.
REQ-014 A rising edge of a clean level SHALL produce a single-cycle pulse. Total latency from a stable raw rise to the pulse is exactly DEBOUNCE_CYCLES+3 cycles.
REQ-015 Count SHALL update on the clock edge following a pulse, with the following rules:
- up-pulse alone: increment;
- down-pulse alone: decrement;
- up and down pulses in the same cycle: clear to all zeros.
REQ-016 Digit arithmetic SHALL be decimal per digit, with carry/borrow rippling within the same cycle. No digit SHALL ever hold a value of 10..15.
REQ-017 Wrap-around SHALL be silent:
- all nines + up gives all zeros;
- all zeros + down gives all nines.
REQ-018 Holding one button SHALL NOT auto-repeat. Pressing the other button while one is held SHALL act as a single press of the second button.
REQ-019 A refresh counter SHALL advance the digit index every REFRESH_CYCLES cycles, counting 0..DIGITS-1 and then wrapping to 0.
REQ-020 Enable7Seg SHALL drive low exactly the bit of the current digit index. Leds7Seg SHALL show the decoded value of that digit in the same cycle, with no extra pipeline stage.
REQ-021 The segment decoder SHALL map values 0-9 as follows:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
REQ-022 When LZ_BLANK=1, any digit that is zero and has only zero digits above it SHALL output 1111111. Digit 0 SHALL never be blanked.
REQ-023 Led1 SHALL follow the clean Btn1 level with one cycle of register delay.

Reset
REQ-024 While rst=1, the following SHALL hold:
- Count=0, Led1=0;
- clean levels, pulses, synchronisers, stability and refresh counters all 0;
- digit index=0, so Enable7Seg has only bit 0 low and Leds7Seg=1000000.
REQ-025 Reset asserted mid-debounce or mid-refresh SHALL abort that operation. A button still held when reset is released SHALL produce a press only after a full DEBOUNCE_CYCLES qualification.

Structure
REQ-026 A shared package/include SHALL hold:
- the BCD digit width constant (4);
- the ten segment code constants;
- the blank code constant.
REQ-027 Debouncing SHALL be a sub-module, btn_debounce (synchroniser, stability counter, clean level, rise pulse), instantiated twice.
REQ-028 Counter widths SHALL be derived with $clog2 from DEBOUNCE_CYCLES, REFRESH_CYCLES and DIGITS.

Verification (DIGITS=4, DEBOUNCE_CYCLES=4, REFRESH_CYCLES=2)
REQ-029 The bench SHALL cover these directed scenarios:
- Reset: rst high, then released -> Count=0000, Led1=0, Enable7Seg=1110, Leds7Seg=1000000.
- Debounce and latency: Btn1 glitches of 3-cycle length -> no change. Btn1 held 10 cycles -> Count=0001 exactly 7 cycles after the rise, with a single increment while held.
- Wrap-around:
  - preload 9999 via presses, then Btn1 -> 0000;
  - from 0000, Btn2 -> 9999;
  - 0099, Btn1 -> 0100 (carry ripple).
- Simultaneous press: Count=0042, Btn1 and Btn2 rise in the same cycle -> Count=0000.
- Display scan with LZ_BLANK=1, Count=0042:
  - Enable7Seg cycles 1110, 1101, 1011, 0111, changing every 2 cycles;
  - Leds7Seg shows 0100100, 0011001, 1111111, 1111111.
- Reset mid-operation: rst pulsed during a held Btn1 after 2 stable cycles -> no increment until 4 new stable cycles have elapsed after release of reset.

Source files
------------

// File: rtl/bcd_counter_pkg.sv
// bcd_counter_pkg
// Shared constants for the BCD up/down counter: digit width, the
// active-low seven-segment codes (gfedcba, bit 6 = g) and a decoder helper.
package bcd_counter_pkg;

    localparam int unsigned BCD_W = 4;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_decode(input logic [BCD_W-1:0] value);
        case (value)
            4'd0:    seg_decode = SEG_0;
            4'd1:    seg_decode = SEG_1;
            4'd2:    seg_decode = SEG_2;
            4'd3:    seg_decode = SEG_3;
            4'd4:    seg_decode = SEG_4;
            4'd5:    seg_decode = SEG_5;
            4'd6:    seg_decode = SEG_6;
            4'd7:    seg_decode = SEG_7;
            4'd8:    seg_decode = SEG_8;
            4'd9:    seg_decode = SEG_9;
            default: seg_decode = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bcd_counter_top_btn_debounce.sv
// btn_debounce
// Synchronises a raw button, qualifies it over DEBOUNCE_CYCLES identical
// samples and produces a one-cycle pulse on each rising edge of the clean level.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   btn      : raw asynchronous button input
//   level    : debounced level
//   rise     : single-cycle pulse, high in the cycle after level rises
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise
);
    import bcd_counter_pkg::*;

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          level_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync    <= '0;
            cnt     <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
        end else begin
            sync    <= {sync[0], btn};
            level_d <= level;
            // Counter runs only while the sample disagrees with the clean
            // level; the DEBOUNCE_CYCLES-th disagreeing sample flips it.
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise = level & ~level_d;

endmodule

// File: rtl/bcd_counter_top.sv
// bcd_counter_top
// Debounced two-button BCD up/down counter with a multiplexed
// seven-segment display driver.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   Btn1, Btn2 : raw count-up / count-down buttons
//   Led1       : registered debounced Btn1 level
//   Count      : packed BCD count, digit 0 in [3:0]
//   Leds7Seg   : active-low segments (gfedcba) of the scanned digit
//   Enable7Seg : active-low one-hot digit enable
module bcd_counter_top #(
    parameter int unsigned DIGITS          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REFRESH_CYCLES  = 50000,
    parameter int unsigned LZ_BLANK        = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Btn1,
    input  logic                  Btn2,
    output logic                  Led1,
    output logic [4*DIGITS-1:0]   Count,
    output logic [6:0]            Leds7Seg,
    output logic [DIGITS-1:0]     Enable7Seg
);
    import bcd_counter_pkg::*;

    localparam int unsigned RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic up_level, up_pulse, down_level, down_pulse;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk   (clk),
        .rst   (rst),
        .btn   (Btn1),
        .level (up_level),
        .rise  (up_pulse)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clk   (clk),
        .rst   (rst),
        .btn   (Btn2),
        .level (down_level),
        .rise  (down_pulse)
    );

    // Decimal increment/decrement with carry/borrow rippling across digits.
    logic [BCD_W*DIGITS-1:0] count_inc, count_dec;
    logic                    carry, borrow;
    logic [BCD_W-1:0]        dig;

    always_comb begin
        count_inc = Count;
        count_dec = Count;
        carry     = 1'b1;
        borrow    = 1'b1;
        dig       = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            dig = Count[i*BCD_W +: BCD_W];
            if (carry) begin
                if (dig >= 4'd9) begin
                    count_inc[i*BCD_W +: BCD_W] = 4'd0;
                end else begin
                    count_inc[i*BCD_W +: BCD_W] = dig + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (dig == 4'd0) begin
                    count_dec[i*BCD_W +: BCD_W] = 4'd9;
                end else begin
                    count_dec[i*BCD_W +: BCD_W] = dig - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Count <= '0;
            Led1  <= 1'b0;
        end else begin
            Led1 <= up_level;
            if (up_pulse && down_pulse) begin
                Count <= '0;
            end else if (up_pulse) begin
                Count <= count_inc;
            end else if (down_pulse) begin
                Count <= count_dec;
            end
        end
    end

    // Display scan
    logic [RW-1:0] ref_cnt;
    logic [IW-1:0] digit_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt   <= '0;
            digit_idx <= '0;
        end else if (ref_cnt == REF_LAST) begin
            ref_cnt   <= '0;
            digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
        end else begin
            ref_cnt <= ref_cnt + 1'b1;
        end
    end

    logic [BCD_W-1:0] cur_digit;
    logic             upper_zero;
    int unsigned      idx;

    always_comb begin
        idx        = 32'(digit_idx);
        cur_digit  = Count[idx*BCD_W +: BCD_W];
        Enable7Seg = '1;
        Enable7Seg[digit_idx] = 1'b0;
        // Blank when this digit and every digit above it are zero.
        upper_zero = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (i >= idx && Count[i*BCD_W +: BCD_W] != 4'd0) begin
                upper_zero = 1'b0;
            end
        end
        if (LZ_BLANK != 0 && idx != 0 && upper_zero) begin
            Leds7Seg = SEG_BLANK;
        end else begin
            Leds7Seg = seg_decode(cur_digit);
        end
    end

endmodule

// File: tb/tb_bcd_counter_top.sv
// tb_bcd_counter_top
// Directed self-checking bench for bcd_counter_top with DIGITS=4,
// DEBOUNCE_CYCLES=4, REFRESH_CYCLES=2, LZ_BLANK=1.
module tb_bcd_counter_top;

    logic        clk = 1'b0;
    logic        rst;
    logic        Btn1, Btn2;
    logic        Led1;
    logic [15:0] Count;
    logic [6:0]  Leds7Seg;
    logic [3:0]  Enable7Seg;

    int tests = 0;
    int fails = 0;

    bcd_counter_top #(
        .DIGITS          (4),
        .DEBOUNCE_CYCLES (4),
        .REFRESH_CYCLES  (2),
        .LZ_BLANK        (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .Btn1       (Btn1),
        .Btn2       (Btn2),
        .Led1       (Led1),
        .Count      (Count),
        .Leds7Seg   (Leds7Seg),
        .Enable7Seg (Enable7Seg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Press for 'hold' cycles, then release and let the clean level fall.
    task automatic press(input logic up, input logic down, input int hold);
        @(negedge clk);
        Btn1 = up;
        Btn2 = down;
        repeat (hold) @(negedge clk);
        Btn1 = 1'b0;
        Btn2 = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    logic [3:0] exp_en  [8];
    logic [6:0] exp_seg [8];
    int         n;

    initial begin
        rst  = 1'b1;
        Btn1 = 1'b0;
        Btn2 = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_count", Count, 32'h0000);
        chk("rst_led1", Led1, 0);
        chk("rst_en", Enable7Seg, 4'b1110);
        chk("rst_seg", Leds7Seg, 7'b1000000);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_count", Count, 32'h0000);
        chk("post_rst_en", Enable7Seg, 4'b1110);
        chk("post_rst_seg", Leds7Seg, 7'b1000000);

        // 3-cycle glitch is rejected
        Btn1 = 1'b1;
        repeat (3) @(negedge clk);
        Btn1 = 1'b0;
        repeat (12) @(negedge clk);
        chk("glitch_count", Count, 32'h0000);
        chk("glitch_led1", Led1, 0);

        // Held 10 cycles: one increment, 7 cycles after the rise
        Btn1 = 1'b1;
        repeat (6) @(negedge clk);
        chk("lat_6", Count, 32'h0000);
        @(negedge clk);
        chk("lat_7", Count, 32'h0001);
        chk("lat_led1", Led1, 1);
        repeat (3) @(negedge clk);
        Btn1 = 1'b0;
        repeat (12) @(negedge clk);
        chk("hold_single", Count, 32'h0001);
        chk("release_led1", Led1, 0);

        // Down to zero, then wrap to 9999, then wrap up to 0000
        press(1'b0, 1'b1, 9);
        chk("down_to_0", Count, 32'h0000);
        press(1'b0, 1'b1, 9);
        chk("wrap_down", Count, 32'h9999);
        press(1'b1, 1'b0, 9);
        chk("wrap_up", Count, 32'h0000);

        // 0099 -> 0100 carry ripple
        for (int i = 0; i < 99; i++) press(1'b1, 1'b0, 9);
        chk("preload_99", Count, 32'h0099);
        press(1'b1, 1'b0, 9);
        chk("carry_100", Count, 32'h0100);

        // 0100 -> 0042 (borrow ripple), then simultaneous press clears
        for (int i = 0; i < 58; i++) press(1'b0, 1'b1, 9);
        chk("borrow_42", Count, 32'h0042);
        press(1'b1, 1'b1, 9);
        chk("simul_clear", Count, 32'h0000);

        // Display scan at 0042 with leading-zero blanking
        for (int i = 0; i < 42; i++) press(1'b1, 1'b0, 9);
        chk("scan_count", Count, 32'h0042);
        exp_en[0] = 4'b1110; exp_seg[0] = 7'b0100100;
        exp_en[1] = 4'b1110; exp_seg[1] = 7'b0100100;
        exp_en[2] = 4'b1101; exp_seg[2] = 7'b0011001;
        exp_en[3] = 4'b1101; exp_seg[3] = 7'b0011001;
        exp_en[4] = 4'b1011; exp_seg[4] = 7'b1111111;
        exp_en[5] = 4'b1011; exp_seg[5] = 7'b1111111;
        exp_en[6] = 4'b0111; exp_seg[6] = 7'b1111111;
        exp_en[7] = 4'b0111; exp_seg[7] = 7'b1111111;
        n = 0;
        while (Enable7Seg == 4'b1110 && n < 20) begin
            @(negedge clk);
            n++;
        end
        while (Enable7Seg != 4'b1110 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("scan_sync", {31'b0, n < 20}, 1);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("scan_en_%0d", k), Enable7Seg, exp_en[k]);
            chk($sformatf("scan_seg_%0d", k), Leds7Seg, exp_seg[k]);
            @(negedge clk);
        end
        chk("scan_wrap_en", Enable7Seg, 4'b1110);

        // Reset during a held Btn1 after 2 stable cycles
        Btn1 = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_count", Count, 32'h0000);
        chk("midrst_en", Enable7Seg, 4'b1110);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("midrst_requal_6", Count, 32'h0000);
        @(negedge clk);
        chk("midrst_requal_7", Count, 32'h0001);
        Btn1 = 1'b0;
        repeat (12) @(negedge clk);
        chk("midrst_final", Count, 32'h0001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
